// File: rtl/pc_id_pkg.sv
// Shared constants for the fetch/decode front end: RV32I major opcodes,
// decoded instruction-format codes and the NOP returned outside the ROM.
package pc_id_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd7
  } fmt_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_decode_imm_gen.sv
// imm_gen: combinational RV32I format classification and immediate
// extraction; the 32-bit immediate is sign-extended (or truncated) to XLEN.
module imm_gen
  import pc_id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt
);

  logic [31:0] imm32;

  // Classify by opcode and assemble the format's immediate bits.
  always_comb begin
    imm32 = '0;
    fmt   = FMT_X;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                 instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                 instr[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt   = FMT_R;
        imm32 = '0;
      end
      default: begin
        fmt   = FMT_X;
        imm32 = '0;
      end
    endcase
  end

  // Signed cast keeps the sign bit when widening to XLEN.
  always_comb begin
    imm = XLEN'(signed'(imm32));
  end

endmodule

// File: rtl/pc_fetch_decode.sv
// pc_fetch_decode: program counter, instruction ROM and registered decode
// output with valid/ready backpressure and jump redirect/squash.
// Optional feature macro: PC_ID_MISALIGN_TRAP_EN (drop misaligned jumps and
// pulse the misalign output instead).
module pc_fetch_decode
  import pc_id_pkg::*;
#(
  parameter int              PC_W       = 9,
  parameter int              IMEM_DEPTH = 128,
  parameter int              XLEN       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter string           IMEM_FILE  = "imem.hex"
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmpa,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [31:0]     Iout,
  output logic [PC_W-1:0] PCout,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  output logic [4:0]      RD,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] IMM,
  output logic [2:0]      fmt
`ifdef PC_ID_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [31:0] mem [IMEM_DEPTH];

  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
`ifdef PC_ID_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
`endif

  logic [PC_W-3:0] widx;
  logic [AW-1:0]   ridx;
  logic [31:0]     rom_word;
  logic            jmp_take;
  fmt_t            fmt_w;

  // ROM read at the current PC; words past the ROM read back as NOP.
  always_comb begin
    widx     = pc_q[PC_W-1:2];
    ridx     = AW'(widx);
    rom_word = NOP_INSTR;
    if (32'(widx) < 32'(IMEM_DEPTH)) begin
      rom_word = mem[ridx];
    end
  end

  // Next state: jump squashes the output; otherwise advance when the
  // output register is empty or being accepted, else hold.
  always_comb begin
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    jmp_take = jmp_en;
`ifdef PC_ID_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
    if (jmp_en && (jmpa[1:0] != 2'b00)) begin
      jmp_take   = 1'b0;
      misalign_d = 1'b1;
    end
`endif
    if (jmp_take) begin
      pc_d    = {jmpa[PC_W-1:2], 2'b00};
      valid_d = 1'b0;
    end else if (!valid_q || out_ready) begin
      instr_d  = rom_word;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + PC_W'(4);
    end
  end

  // State registers; reset takes priority over any jump request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
`ifdef PC_ID_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
`ifdef PC_ID_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr (instr_q),
    .imm   (IMM),
    .fmt   (fmt_w)
  );

  // Field decode straight from the registered instruction word.
  always_comb begin
    out_valid = valid_q;
    Iout      = instr_q;
    PCout     = pc_out_q;
    Rs1       = instr_q[19:15];
    Rs2       = instr_q[24:20];
    RD        = instr_q[11:7];
    opcode    = instr_q[6:0];
    funct3    = instr_q[14:12];
    funct7    = instr_q[31:25];
    fmt       = fmt_w;
`ifdef PC_ID_MISALIGN_TRAP_EN
    misalign  = misalign_q;
`endif
  end

endmodule

// File: tb/tb_pc_fetch_decode.sv
// Scoreboard bench for pc_fetch_decode (PC_W=9, 64-word ROM preloaded by
// hierarchical writes, so the upper half of the address space reads NOP).
module tb_pc_fetch_decode;

  localparam int PW    = 9;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          jmp_en;
  logic [PW-1:0] jmpa;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   Iout;
  logic [PW-1:0] PCout;
  logic [4:0]    Rs1, Rs2, RD;
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3, fmt;
  logic [31:0]   IMM;
`ifdef PC_ID_MISALIGN_TRAP_EN
  logic          misalign;
`endif

  pc_fetch_decode #(
    .PC_W       (PW),
    .IMEM_DEPTH (DEPTH),
    .XLEN       (32),
    .RESET_PC   (9'h000),
    .IMEM_FILE  ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .jmp_en    (jmp_en),
    .jmpa      (jmpa),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .Iout      (Iout),
    .PCout     (PCout),
    .Rs1       (Rs1),
    .Rs2       (Rs2),
    .RD        (RD),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .IMM       (IMM),
    .fmt       (fmt)
`ifdef PC_ID_MISALIGN_TRAP_EN
    ,
    .misalign  (misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pc;
    logic [31:0]   instr;
    logic [31:0]   imm;
    logic [2:0]    fmt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rom_img [DEPTH];
  logic [31:0] rom_imm [DEPTH];
  logic [2:0]  rom_fmt [DEPTH];
  int          checks = 0;
  int          errors = 0;

  function automatic exp_t model(input logic [PW-1:0] pc);
    exp_t        m;
    int unsigned w;
    w       = 32'(pc[PW-1:2]);
    m.pc    = pc;
    m.instr = 32'h0000_0013;
    m.imm   = 32'h0;
    m.fmt   = 3'd1;
    if (w < DEPTH) begin
      m.instr = rom_img[w];
      m.imm   = rom_imm[w];
      m.fmt   = rom_fmt[w];
    end
    return m;
  endfunction

  task automatic push_seq(input logic [PW-1:0] start, input int n);
    for (int k = 0; k < n; k++) sb.push_back(model(start + PW'(4 * k)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d items left, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: PCout=%h, required no transfer", PCout);
      end else begin
        e = sb.pop_front();
        if (PCout !== e.pc) begin
          errors++;
          $display("FAIL sb_pc: got %h required %h", PCout, e.pc);
        end
        checks++;
        if (Iout !== e.instr) begin
          errors++;
          $display("FAIL sb_instr@%h: got %h required %h", e.pc, Iout, e.instr);
        end
        checks++;
        if (IMM !== e.imm) begin
          errors++;
          $display("FAIL sb_imm@%h: got %h required %h", e.pc, IMM, e.imm);
        end
        checks++;
        if (fmt !== e.fmt) begin
          errors++;
          $display("FAIL sb_fmt@%h: got %0d required %0d", e.pc, fmt, e.fmt);
        end
        checks++;
        if ({funct7, Rs2, Rs1, funct3, RD, opcode} !== e.instr) begin
          errors++;
          $display("FAIL sb_fields@%h: got %h required %h", e.pc,
                   {funct7, Rs2, Rs1, funct3, RD, opcode}, e.instr);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || PCout !== '0 || Iout !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b PCout=%h Iout=%h required 0/0/0",
               out_valid, PCout, Iout);
    end
    rst = 1'b0;
    for (int i = 0; i < 3 && out_valid !== 1'b1; i++) tick();
    checks++;
    if (out_valid !== 1'b1 || PCout !== 9'h000) begin
      errors++;
      $display("FAIL first_valid: valid=%b PCout=%h required 1/000", out_valid, PCout);
    end
    push_seq(9'h000, 4);
    drain(20);
  endtask

  task automatic test_backpressure();
    exp_t e;
    e = model(9'h010);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || PCout !== e.pc || Iout !== e.instr || IMM !== e.imm) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b PCout=%h Iout=%h IMM=%h required 1/%h/%h/%h",
                 i, out_valid, PCout, Iout, IMM, e.pc, e.instr, e.imm);
      end
    end
    push_seq(9'h010, 8);
    drain(30);
  endtask

  task automatic test_jump();
    jmp_en = 1'b1;
    jmpa   = 9'h040;
    tick();
    jmp_en = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL jump_squash: valid=%b required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || PCout !== 9'h040 || Iout !== rom_img[16]) begin
      errors++;
      $display("FAIL jump_target: valid=%b PCout=%h Iout=%h required 1/040/%h",
               out_valid, PCout, Iout, rom_img[16]);
    end
    push_seq(9'h040, 2);
    drain(10);
    jmp_en = 1'b1;
    jmpa   = 9'h080;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL held_jump_squash[%0d]: valid=%b required 0", i, out_valid);
      end
    end
    jmp_en = 1'b0;
    push_seq(9'h080, 2);
    drain(10);
  endtask

  task automatic test_wrap();
    jmp_en = 1'b1;
    jmpa   = 9'h0FC;
    tick();
    jmp_en = 1'b0;
    push_seq(9'h0FC, 3);
    drain(12);
    jmp_en = 1'b1;
    jmpa   = 9'h1F8;
    tick();
    jmp_en = 1'b0;
    push_seq(9'h1F8, 4);
    drain(12);
  endtask

  task automatic test_reset_mid();
    rst    = 1'b1;
    jmp_en = 1'b1;
    jmpa   = 9'h040;
    tick();
    rst    = 1'b0;
    jmp_en = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || PCout !== '0 || Iout !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b PCout=%h Iout=%h required 0/0/0",
               out_valid, PCout, Iout);
    end
    push_seq(9'h000, 2);
    drain(10);
  endtask

  task automatic test_misalign();
    jmp_en = 1'b1;
    jmpa   = 9'h042;
    tick();
    jmp_en = 1'b0;
`ifdef PC_ID_MISALIGN_TRAP_EN
    checks++;
    if (out_valid !== 1'b1 || PCout !== 9'h008 || misalign !== 1'b1) begin
      errors++;
      $display("FAIL misalign_drop: valid=%b PCout=%h misalign=%b required 1/008/1",
               out_valid, PCout, misalign);
    end
    tick();
    checks++;
    if (misalign !== 1'b0 || PCout !== 9'h008) begin
      errors++;
      $display("FAIL misalign_pulse: misalign=%b PCout=%h required 0/008", misalign, PCout);
    end
    push_seq(9'h008, 2);
`else
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_squash: valid=%b required 0", out_valid);
    end
    push_seq(9'h040, 2);
`endif
    drain(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    jmp_en    = 1'b0;
    jmpa      = '0;
    out_ready = 1'b0;
    rom_img[0]  = 32'h0050_0093; rom_imm[0]  = 32'h0000_0005; rom_fmt[0]  = 3'd1; // addi x1,x0,5
    rom_img[1]  = 32'hFFF0_0113; rom_imm[1]  = 32'hFFFF_FFFF; rom_fmt[1]  = 3'd1; // addi x2,x0,-1
    rom_img[2]  = 32'h0020_81B3; rom_imm[2]  = 32'h0000_0000; rom_fmt[2]  = 3'd0; // add x3,x1,x2
    rom_img[3]  = 32'hFE20_AE23; rom_imm[3]  = 32'hFFFF_FFFC; rom_fmt[3]  = 3'd2; // sw x2,-4(x1)
    rom_img[4]  = 32'hFE20_8CE3; rom_imm[4]  = 32'hFFFF_FFF8; rom_fmt[4]  = 3'd3; // beq x1,x2,-8
    rom_img[5]  = 32'h8000_02B7; rom_imm[5]  = 32'h8000_0000; rom_fmt[5]  = 3'd4; // lui x5,0x80000
    rom_img[6]  = 32'hFF1F_F0EF; rom_imm[6]  = 32'hFFFF_FFF0; rom_fmt[6]  = 3'd5; // jal x1,-16
    rom_img[7]  = 32'h1234_5397; rom_imm[7]  = 32'h1234_5000; rom_fmt[7]  = 3'd4; // auipc x7
    rom_img[8]  = 32'h8000_A403; rom_imm[8]  = 32'hFFFF_F800; rom_fmt[8]  = 3'd1; // lw x8,-2048(x1)
    rom_img[9]  = 32'hFFFF_FFFF; rom_imm[9]  = 32'h0000_0000; rom_fmt[9]  = 3'd7; // unknown
    rom_img[10] = 32'h0000_8067; rom_imm[10] = 32'h0000_0000; rom_fmt[10] = 3'd1; // jalr x0,0(x1)
    rom_img[11] = 32'h0000_0073; rom_imm[11] = 32'h0000_0000; rom_fmt[11] = 3'd1; // ecall
    for (int i = 12; i < DEPTH; i++) begin
      rom_img[i] = {12'(i), 5'd0, 3'd0, 5'd2, 7'b0010011};              // addi x2,x0,i
      rom_imm[i] = 32'(i);
      rom_fmt[i] = 3'd1;
    end
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = rom_img[i];

    test_reset();
    test_backpressure();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_misalign();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
